// File: rtl/aes_pkg.sv
// Shared AES definitions: byte-array state type, round count, xtime and the S-box table.
package aes_pkg;

  typedef logic [7:0] aes_state_t [0:3][0:3];

  localparam int unsigned NR = 10;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, one byte in, one byte out; shared with the SubBytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 round-key generator: loads the cipher key on start and
// produces one further round key per next pulse, up to round NR.
module aes_key_schedule #(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  aes_pkg::aes_state_t i_key_in,
  input  logic                i_next,
  output aes_pkg::aes_state_t o_round_key,
  output logic [3:0]          o_round_idx,
  output logic                o_key_valid,
  output logic                o_last,
  output logic                o_busy
);
  import aes_pkg::*;

  if (NR != 10) begin : g_nr_check
    $error("aes_key_schedule: NR must be 10 for AES-128");
  end

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e     r_state, w_state_d;
  aes_state_t r_round_key, w_round_key_d, w_expand;
  logic [3:0] r_round_idx, w_round_idx_d;
  logic [7:0] r_rcon, w_rcon_d;
  logic [7:0] w_t [0:3];

  // RotWord + SubWord on column 3: row r takes the byte from row r+1.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte(r_round_key[(g + 1) % 4][3]),
      .o_byte(w_t[g])
    );
  end

  always_comb begin
    w_expand = r_round_key;
    for (int r = 0; r < 4; r++) begin
      w_expand[r][0] = r_round_key[r][0] ^ w_t[r] ^ ((r == 0) ? r_rcon : 8'h00);
      for (int c = 1; c < 4; c++) begin
        w_expand[r][c] = r_round_key[r][c] ^ w_expand[r][c-1];
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_round_key_d = r_round_key;
    w_round_idx_d = r_round_idx;
    w_rcon_d      = r_rcon;
    if (i_start) begin
      w_state_d     = StActive;
      w_round_key_d = i_key_in;
      w_round_idx_d = 4'd0;
      w_rcon_d      = 8'h01;
    end else if (i_next && r_state == StActive) begin
      if (r_round_idx == 4'(NR)) begin
        // Final key stays visible on round_key, just no longer flagged valid.
        w_state_d     = StIdle;
        w_round_idx_d = 4'd0;
      end else begin
        w_round_key_d = w_expand;
        w_round_idx_d = r_round_idx + 4'd1;
        w_rcon_d      = xtime(r_rcon);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_round_idx <= 4'd0;
      r_rcon      <= 8'h01;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_round_key[r][c] <= 8'h00;
        end
      end
    end else begin
      r_state     <= w_state_d;
      r_round_key <= w_round_key_d;
      r_round_idx <= w_round_idx_d;
      r_rcon      <= w_rcon_d;
    end
  end

  assign o_round_key = r_round_key;
  assign o_round_idx = r_round_idx;
  assign o_key_valid = (r_state == StActive);
  assign o_busy      = (r_state == StActive);
  assign o_last      = (r_state == StActive) && (r_round_idx == 4'(NR));

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: stimulus pushes expected outputs into a
// queue tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_aes_key_schedule;
  import aes_pkg::*;

  localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyFipsR1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KeyFipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KeyZeroR1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KeySeq = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KeySeqR1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  typedef struct {
    string        name;
    logic [127:0] key;
    bit           chk_key;
    logic [3:0]   idx;
    bit           valid;
    int           due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic       i_next = 1'b0;
  aes_state_t i_key_in;
  aes_state_t o_round_key;
  logic [3:0] o_round_idx;
  logic       o_key_valid, o_last, o_busy;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  aes_key_schedule #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_key_in   (i_key_in),
    .i_next     (i_next),
    .o_round_key(o_round_key),
    .o_round_idx(o_round_idx),
    .o_key_valid(o_key_valid),
    .o_last     (o_last),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Byte k of the FIPS hex string sits in column k/4, row k%4.
  function automatic aes_state_t to_state(input logic [127:0] k);
    aes_state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = k[127 - 8 * (4 * c + r) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input aes_state_t s);
    logic [127:0] k;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) k[127 - 8 * (4 * c + r) -: 8] = s[r][c];
    return k;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if (e.chk_key) check({e.name, ".key"}, from_state(o_round_key), e.key);
    check({e.name, ".idx"}, 128'(o_round_idx), 128'(e.idx));
    check({e.name, ".valid"}, 128'(o_key_valid), 128'(e.valid));
    check({e.name, ".busy"}, 128'(o_busy), 128'(e.valid));
    check({e.name, ".last"}, 128'(o_last), 128'(e.valid && e.idx == 4'd10));
  endtask

  always @(negedge clk) begin
    n_checks++;
    if (o_last !== (o_key_valid && o_round_idx == 4'd10)) begin
      n_fail++;
      $display("FAIL last_invariant: last=%b valid=%b idx=%0d", o_last, o_key_valid, o_round_idx);
    end
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) check_entry(sb_q.pop_front());
  end

  // Called at a negedge: the expected state is due after the coming posedge.
  task automatic expect_next(input string name, input logic [127:0] k, input bit chk,
                             input int idx, input bit v);
    exp_t e;
    e.name = name; e.key = k; e.chk_key = chk; e.idx = 4'(idx); e.valid = v; e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic pulse(input bit s, input bit n, input logic [127:0] k);
    i_start = s;
    i_next = n;
    i_key_in = s ? to_state(k) : to_state(128'($urandom) ^ ~k);
    @(negedge clk);
    i_start = 1'b0;
    i_next = 1'b0;
    i_key_in = to_state({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    i_key_in = to_state(128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_next("reset", 128'h0, 1'b1, 0, 1'b0);
    idle(1);

    expect_next("fips_load", KeyFips, 1'b1, 0, 1'b1);
    pulse(1'b1, 1'b0, KeyFips);
    expect_next("fips_r1", KeyFipsR1, 1'b1, 1, 1'b1);
    pulse(1'b0, 1'b1, '0);
    for (int i = 2; i <= 10; i++) begin
      idle($urandom_range(0, 3));
      expect_next($sformatf("fips_r%0d", i), KeyFipsR10, i == 10, i, 1'b1);
      pulse(1'b0, 1'b1, '0);
    end
    idle(2);
    expect_next("fips_done", KeyFipsR10, 1'b1, 0, 1'b0);
    pulse(1'b0, 1'b1, '0);

    expect_next("zero_load", 128'h0, 1'b1, 0, 1'b1);
    pulse(1'b1, 1'b0, 128'h0);
    expect_next("zero_r1", KeyZeroR1, 1'b1, 1, 1'b1);
    pulse(1'b0, 1'b1, '0);

    expect_next("fips_reload", KeyFips, 1'b1, 0, 1'b1);
    pulse(1'b1, 1'b0, KeyFips);
    for (int i = 1; i <= 5; i++) begin
      expect_next("to_idx5", '0, 1'b0, i, 1'b1);
      pulse(1'b0, 1'b1, '0);
    end
    expect_next("restart_seq", KeySeq, 1'b1, 0, 1'b1);
    pulse(1'b1, 1'b0, KeySeq);
    expect_next("seq_r1", KeySeqR1, 1'b1, 1, 1'b1);
    pulse(1'b0, 1'b1, '0);
    expect_next("start_beats_next", KeyFips, 1'b1, 0, 1'b1);
    pulse(1'b1, 1'b1, KeyFips);
    for (int i = 1; i <= 10; i++) begin
      expect_next("run_out", KeyFipsR10, i == 10, i, 1'b1);
      pulse(1'b0, 1'b1, '0);
    end
    expect_next("end_again", KeyFipsR10, 1'b1, 0, 1'b0);
    pulse(1'b0, 1'b1, '0);
    expect_next("next_in_idle", KeyFipsR10, 1'b1, 0, 1'b0);
    pulse(1'b0, 1'b1, '0);
    idle(1);

    expect_next("pre_rst_load", KeyFips, 1'b1, 0, 1'b1);
    pulse(1'b1, 1'b0, KeyFips);
    for (int i = 1; i <= 4; i++) begin
      expect_next("to_idx4", '0, 1'b0, i, 1'b1);
      pulse(1'b0, 1'b1, '0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst.key", from_state(o_round_key), 128'h0);
    check("async_rst.idx", 128'(o_round_idx), 128'h0);
    check("async_rst.valid", 128'(o_key_valid), 128'h0);
    check("async_rst.busy", 128'(o_busy), 128'h0);
    check("async_rst.last", 128'(o_last), 128'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    expect_next("post_rst_idle", 128'h0, 1'b1, 0, 1'b0);
    idle(1);
    expect_next("post_rst_load", KeySeq, 1'b1, 0, 1'b1);
    pulse(1'b1, 1'b0, KeySeq);
    idle(3);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
